freelist: RTL

//  Physical-register free list for the dual-issue rename stage. Supplies new destination

---
 rtl/freelist.sv | 115 +++++++++++
 1 files changed

// File: rtl/freelist.sv
`default_nettype none
// ============================================================================
//  Module      : freelist
//  Description : Physical-register free list for a dual-issue rename stage.
//                Circular buffer of free preg indices with a speculative head
//                (rename allocations), an architectural head (committed
//                allocations) and a tail (reclaimed pregs). A flush rewinds
//                the speculative head onto the architectural head.
//  Revision    : 1.0  initial release
// ============================================================================
module freelist #(
   parameter int NUM_PREG = 64,
   parameter int FL_DEPTH = 32,
   parameter int PREG_W   = 6
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              instr0_alloc_req,
   input  logic              instr1_alloc_req,
   output logic              fl_can_alloc,
   output logic [PREG_W-1:0] fl2rename_instr0_prd,
   output logic [PREG_W-1:0] fl2rename_instr1_prd,
   input  logic              commits0_valid,
   input  logic              commits0_need_to_wb,
   input  logic [PREG_W-1:0] commits0_old_prd,
   input  logic              commits1_valid,
   input  logic              commits1_need_to_wb,
   input  logic [PREG_W-1:0] commits1_old_prd,
   input  logic              flush_valid,
   output logic [PREG_W-1:0] fl_free_count
);

   // Index selects a slot; the extra pointer bit tells full apart from empty.
   localparam int c_IDX_W = $clog2(FL_DEPTH);
   localparam int c_PTR_W = c_IDX_W + 1;
   // The first preg that is not part of the reset architectural mapping.
   localparam int c_FIRST_FREE = NUM_PREG - FL_DEPTH;

   logic [PREG_W-1:0]  r_entry [FL_DEPTH];
   logic [c_PTR_W-1:0] r_spec_head;
   logic [c_PTR_W-1:0] r_arch_head;
   logic [c_PTR_W-1:0] r_tail;

   logic [1:0]         w_need;
   logic [1:0]         w_nfree;
   logic               w_free0;
   logic               w_free1;
   logic               w_alloc;
   logic [c_PTR_W-1:0] w_free_count;
   logic [c_PTR_W-1:0] w_arch_head_next;
   logic [c_PTR_W-1:0] w_tail_next;
   logic [c_PTR_W-1:0] w_spec_head_next;
   logic [c_IDX_W-1:0] w_spec_idx;
   logic [c_IDX_W-1:0] w_spec_idx1;
   logic [c_IDX_W-1:0] w_tail_idx0;
   logic [c_IDX_W-1:0] w_tail_idx1;

   // Request/free accounting, allocation grant and next-pointer arithmetic.
   always_comb begin
      w_need           = {1'b0, instr0_alloc_req} + {1'b0, instr1_alloc_req};
      w_free0          = commits0_valid & commits0_need_to_wb;
      w_free1          = commits1_valid & commits1_need_to_wb;
      w_nfree          = {1'b0, w_free0} + {1'b0, w_free1};
      // Occupancy uses this cycle's pointers only: same-cycle frees are not
      // visible to allocation, which keeps the grant path short.
      w_free_count     = r_tail - r_spec_head;
      fl_can_alloc     = (w_free_count >= c_PTR_W'(w_need));
      w_alloc          = fl_can_alloc & ~flush_valid;
      w_arch_head_next = r_arch_head + c_PTR_W'(w_nfree);
      w_tail_next      = r_tail + c_PTR_W'(w_nfree);
      w_spec_head_next = r_spec_head;
      if (flush_valid) begin
         w_spec_head_next = w_arch_head_next;
      end else if (w_alloc) begin
         w_spec_head_next = r_spec_head + c_PTR_W'(w_need);
      end
      // Slot 1 reads/writes one position further only when slot 0 is active.
      w_spec_idx       = r_spec_head[c_IDX_W-1:0];
      w_spec_idx1      = w_spec_idx + c_IDX_W'(instr0_alloc_req);
      w_tail_idx0      = r_tail[c_IDX_W-1:0];
      w_tail_idx1      = w_tail_idx0 + c_IDX_W'(w_free0);
   end

   // Zero-latency peeks of the next free pregs and the occupancy output.
   always_comb begin
      fl2rename_instr0_prd = r_entry[w_spec_idx];
      fl2rename_instr1_prd = r_entry[w_spec_idx1];
      fl_free_count        = PREG_W'(w_free_count);
   end

   // Pointer registers and free-list storage; reset fills the list with the
   // pregs above the architectural mapping and marks it full.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_spec_head <= '0;
         r_arch_head <= '0;
         r_tail      <= c_PTR_W'(FL_DEPTH);
         for (int i = 0; i < FL_DEPTH; i++) begin
            r_entry[i] <= PREG_W'(c_FIRST_FREE + i);
         end
      end else begin
         r_spec_head <= w_spec_head_next;
         r_arch_head <= w_arch_head_next;
         r_tail      <= w_tail_next;
         if (w_free0) begin
            r_entry[w_tail_idx0] <= commits0_old_prd;
         end
         if (w_free1) begin
            r_entry[w_tail_idx1] <= commits1_old_prd;
         end
      end
   end

endmodule
`default_nettype wire
